// File: rtl/demux_striping_nlane_if.sv
// Bus between the word source and the N-lane striping demux.
// The master drives words and the width request. The slave (the demux) returns
// the lane words, the per-lane valids and the stripe status.
interface demux_striping_nlane_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LANES = 4
);
  logic [WIDTH-1:0]       data_input;
  logic                   valid_in;
  logic [1:0]             width_sel;
  logic [LANES*WIDTH-1:0] lane_data;
  logic [LANES-1:0]       valid_out;
  logic                   stripe_end;
  logic [3:0]             active_lanes;

  modport master (
    output data_input,
    output valid_in,
    output width_sel,
    input  lane_data,
    input  valid_out,
    input  stripe_end,
    input  active_lanes
  );

  modport slave (
    input  data_input,
    input  valid_in,
    input  width_sel,
    output lane_data,
    output valid_out,
    output stripe_end,
    output active_lanes
  );
endinterface

// File: rtl/demux_striping_nlane.sv
// Round-robin striping of valid words across 1/2/4/8 active lanes (capped at LANES).
// Outputs are registered, so a word appears on its lane one cycle after it is accepted.
// A new link width is only adopted when the lane pointer is at zero, which is a stripe
// boundary. This keeps a stripe from being split across two widths.
module demux_striping_nlane #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LANES = 4
) (
  input logic                   clk_2f,
  input logic                   reset_L,
  demux_striping_nlane_if.slave bus
);

  localparam int unsigned PTR_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [3:0]  LANES_W = 4'(LANES);

  logic [PTR_W-1:0]       r_ptr;
  logic [3:0]             r_active;
  logic [LANES*WIDTH-1:0] r_lane_data;
  logic [LANES-1:0]       r_valid_out;
  logic                   r_stripe_end;

  logic [3:0]             w_req_raw;
  logic [3:0]             w_req;
  logic [3:0]             w_eff;
  logic [3:0]             w_ptr_ext;
  logic                   w_ptr_zero;
  logic                   w_last;
  logic [LANES-1:0]       w_sel_oh;

  // Decode the requested width, clamp it to the lanes that exist, and pick the
  // width that governs this cycle's wrap decision.
  always_comb begin
    w_req_raw  = 4'd1 << bus.width_sel;
    w_req      = (w_req_raw > LANES_W) ? LANES_W : w_req_raw;
    w_ptr_ext  = 4'(r_ptr);
    w_ptr_zero = (r_ptr == '0);
    // At a boundary the incoming word already obeys the new width.
    w_eff      = w_ptr_zero ? w_req : r_active;
    w_last     = (w_ptr_ext == (w_eff - 4'd1));
    w_sel_oh   = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      w_sel_oh[k] = (w_ptr_ext == 4'(k));
    end
  end

  // Pointer, width latch and registered lane outputs.
  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      r_ptr        <= '0;
      r_active     <= 4'd1;
      r_lane_data  <= '0;
      r_valid_out  <= '0;
      r_stripe_end <= 1'b0;
    end else begin
      if (w_ptr_zero) begin
        r_active <= w_req;
      end
      if (bus.valid_in) begin
        for (int k = 0; k < int'(LANES); k++) begin
          if (w_sel_oh[k]) begin
            r_lane_data[k*WIDTH +: WIDTH] <= bus.data_input;
          end
        end
        r_valid_out  <= w_sel_oh;
        r_stripe_end <= w_last;
        r_ptr        <= w_last ? '0 : (r_ptr + PTR_W'(1));
      end else begin
        // Idle cycles leave the pointer alone, so a gap does not break a stripe.
        r_valid_out  <= '0;
        r_stripe_end <= 1'b0;
      end
    end
  end

  assign bus.lane_data    = r_lane_data;
  assign bus.valid_out    = r_valid_out;
  assign bus.stripe_end   = r_stripe_end;
  assign bus.active_lanes = r_active;

endmodule

// File: tb/tb_demux_striping_nlane.sv
// Self-checking bench for demux_striping_nlane (WIDTH=32, LANES=4).
module tb_demux_striping_nlane;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned LANES = 4;

  logic clk_2f;
  logic reset_L;
  int   total;
  int   bad;

  demux_striping_nlane_if #(.WIDTH(WIDTH), .LANES(LANES)) bus ();

  demux_striping_nlane #(.WIDTH(WIDTH), .LANES(LANES)) dut (
    .clk_2f  (clk_2f),
    .reset_L (reset_L),
    .bus     (bus)
  );

  initial clk_2f = 1'b0;
  always #5 clk_2f = ~clk_2f;

  function automatic logic [31:0] lane_word(input int k);
    return bus.lane_data[k*WIDTH +: WIDTH];
  endfunction

  // Drives one cycle of input at a falling edge, then returns at the next falling edge.
  task automatic drive(input logic v, input logic [31:0] d, input logic [1:0] ws);
    bus.valid_in   = v;
    bus.data_input = d;
    bus.width_sel  = ws;
    @(posedge clk_2f);
    @(negedge clk_2f);
  endtask

  task automatic do_reset();
    reset_L        = 1'b0;
    bus.valid_in   = 1'b0;
    bus.data_input = '0;
    bus.width_sel  = 2'd0;
    repeat (2) @(negedge clk_2f);
    reset_L = 1'b1;
  endtask

  task automatic test_reset();
    logic [3:0] exp_vo;
    reset_L = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.valid_in   = 1'($urandom);
      bus.data_input = $urandom;
      bus.width_sel  = 2'($urandom);
      @(posedge clk_2f);
      @(negedge clk_2f);
      total++;
      if (bus.lane_data !== '0 || bus.valid_out !== '0 || bus.stripe_end !== 1'b0 ||
          bus.active_lanes !== 4'd1) begin
        bad++;
        $display("FAIL reset_hold got lanes=%h vo=%b se=%b al=%0d exp 0/0/0/1",
                 bus.lane_data, bus.valid_out, bus.stripe_end, bus.active_lanes);
      end
    end
    reset_L = 1'b1;
    // Put the pointer at 2 in x4, then reset between clock edges.
    drive(1'b1, 32'h11, 2'd2);
    drive(1'b1, 32'h22, 2'd2);
    bus.valid_in = 1'b0;
    #2;
    reset_L = 1'b0;
    #1;
    total++;
    if (bus.lane_data !== '0 || bus.valid_out !== '0 || bus.stripe_end !== 1'b0 ||
        bus.active_lanes !== 4'd1) begin
      bad++;
      $display("FAIL reset_async got lanes=%h vo=%b se=%b al=%0d exp 0/0/0/1",
               bus.lane_data, bus.valid_out, bus.stripe_end, bus.active_lanes);
    end
    @(negedge clk_2f);
    reset_L = 1'b1;
    drive(1'b1, 32'h33, 2'd2);
    exp_vo = 4'b0001;
    total++;
    if (bus.valid_out !== exp_vo || lane_word(0) !== 32'h33) begin
      bad++;
      $display("FAIL reset_first_word got vo=%b l0=%h exp vo=%b l0=33",
               bus.valid_out, lane_word(0), exp_vo);
    end
  endtask

  task automatic test_x4_stream();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'hA0 + 32'(i), 2'd2);
      total++;
      if (bus.valid_out !== 4'(1 << (i % 4)) || lane_word(i % 4) !== 32'hA0 + 32'(i) ||
          bus.stripe_end !== ((i % 4) == 3)) begin
        bad++;
        $display("FAIL x4_stream[%0d] got vo=%b lane=%h se=%b exp vo=%b lane=%h se=%b", i,
                 bus.valid_out, lane_word(i % 4), bus.stripe_end, 4'(1 << (i % 4)),
                 32'hA0 + 32'(i), (i % 4) == 3);
      end
    end
    total++;
    if (bus.active_lanes !== 4'd4) begin
      bad++;
      $display("FAIL x4_active got %0d exp 4", bus.active_lanes);
    end
  endtask

  task automatic test_width_change();
    int exp_lane[6] = '{0, 1, 2, 3, 0, 1};
    bit exp_se[6]   = '{0, 0, 0, 1, 0, 1};
    int exp_al[6]   = '{4, 4, 4, 4, 2, 2};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'hB0 + 32'(i), (i < 2) ? 2'd2 : 2'd1);
      total++;
      if (bus.valid_out !== 4'(1 << exp_lane[i]) || lane_word(exp_lane[i]) !== 32'hB0 + 32'(i) ||
          bus.stripe_end !== exp_se[i] || bus.active_lanes !== 4'(exp_al[i])) begin
        bad++;
        $display("FAIL width_change[%0d] got vo=%b w=%h se=%b al=%0d exp lane%0d se=%b al=%0d",
                 i, bus.valid_out, lane_word(exp_lane[i]), bus.stripe_end, bus.active_lanes,
                 exp_lane[i], exp_se[i], exp_al[i]);
      end
    end
  endtask

  task automatic test_gaps();
    bit          v[6]     = '{1, 0, 0, 1, 0, 1};
    logic [31:0] d[6]     = '{32'hC0, 32'h0, 32'h0, 32'hC1, 32'h0, 32'hC2};
    logic [3:0]  exp_vo[6] = '{4'b0001, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0001};
    logic [31:0] exp_l0[6] = '{32'hC0, 32'hC0, 32'hC0, 32'hC0, 32'hC0, 32'hC2};
    logic [31:0] exp_l1[6] = '{32'hB5, 32'hB5, 32'hB5, 32'hC1, 32'hC1, 32'hC1};
    bit          exp_se[6] = '{0, 0, 0, 1, 0, 0};
    for (int i = 0; i < 6; i++) begin
      drive(v[i], v[i] ? d[i] : $urandom, 2'd1);
      total++;
      if (bus.valid_out !== exp_vo[i] || lane_word(0) !== exp_l0[i] ||
          lane_word(1) !== exp_l1[i] || bus.stripe_end !== exp_se[i]) begin
        bad++;
        $display("FAIL gaps[%0d] got vo=%b l0=%h l1=%h se=%b exp vo=%b l0=%h l1=%h se=%b", i,
                 bus.valid_out, lane_word(0), lane_word(1), bus.stripe_end, exp_vo[i],
                 exp_l0[i], exp_l1[i], exp_se[i]);
      end
    end
  endtask

  task automatic test_clamp_x1();
    // Pointer is at 1 in x2: a request for x8 must wait for this word to close the stripe.
    drive(1'b1, 32'hE0, 2'd3);
    total++;
    if (bus.valid_out !== 4'b0010 || bus.stripe_end !== 1'b1 || bus.active_lanes !== 4'd2) begin
      bad++;
      $display("FAIL clamp_close got vo=%b se=%b al=%0d exp vo=0010 se=1 al=2",
               bus.valid_out, bus.stripe_end, bus.active_lanes);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'hE1 + 32'(i), 2'd3);
      total++;
      if (bus.valid_out !== 4'(1 << i) || lane_word(i) !== 32'hE1 + 32'(i) ||
          bus.stripe_end !== (i == 3) || bus.active_lanes !== 4'd4) begin
        bad++;
        $display("FAIL clamp[%0d] got vo=%b w=%h se=%b al=%0d exp vo=%b al=4", i,
                 bus.valid_out, lane_word(i), bus.stripe_end, bus.active_lanes, 4'(1 << i));
      end
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'hD0 + 32'(i), 2'd0);
      total++;
      if (bus.valid_out !== 4'b0001 || lane_word(0) !== 32'hD0 + 32'(i) ||
          bus.stripe_end !== 1'b1 || bus.active_lanes !== 4'd1) begin
        bad++;
        $display("FAIL x1[%0d] got vo=%b l0=%h se=%b al=%0d exp vo=0001 l0=%h se=1 al=1", i,
                 bus.valid_out, lane_word(0), bus.stripe_end, bus.active_lanes, 32'hD0 + 32'(i));
      end
    end
  endtask

  // Reference: the word count within the current stripe selects the lane. The stripe
  // length is fixed by the width requested when the stripe began.
  task automatic test_random();
    int          pos;
    int          act;
    int          req;
    logic [31:0] m_lane[LANES];
    logic [3:0]  exp_vo;
    bit          exp_se;
    logic        v;
    logic [31:0] d;
    logic [1:0]  ws;
    do_reset();
    pos = 0;
    act = 1;
    for (int k = 0; k < int'(LANES); k++) m_lane[k] = '0;
    for (int c = 0; c < 2000; c++) begin
      v  = ($urandom_range(0, 3) != 0);
      d  = $urandom;
      ws = 2'($urandom);
      req = 1 << ws;
      if (req > int'(LANES)) req = LANES;
      if (pos == 0) act = req;
      if (v) begin
        m_lane[pos] = d;
        exp_vo      = 4'(1 << pos);
        exp_se      = (pos + 1 == act);
        pos         = (pos + 1) % act;
      end else begin
        exp_vo = '0;
        exp_se = 1'b0;
      end
      drive(v, d, ws);
      total++;
      if (bus.valid_out !== exp_vo || bus.stripe_end !== exp_se ||
          bus.active_lanes !== 4'(act) ||
          bus.lane_data !== {m_lane[3], m_lane[2], m_lane[1], m_lane[0]}) begin
        bad++;
        $display("FAIL random[%0d] got vo=%b se=%b al=%0d ld=%h exp vo=%b se=%b al=%0d ld=%h",
                 c, bus.valid_out, bus.stripe_end, bus.active_lanes, bus.lane_data, exp_vo,
                 exp_se, act, {m_lane[3], m_lane[2], m_lane[1], m_lane[0]});
      end
    end
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    reset_L        = 1'b0;
    bus.valid_in   = 1'b0;
    bus.data_input = '0;
    bus.width_sel  = 2'd0;
    @(negedge clk_2f);
    test_reset();
    test_x4_stream();
    test_width_change();
    test_gaps();
    test_clamp_x1();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/demux_striping_nlane.md
Name: demux_striping_nlane

Overview:
- Parametrised successor to the two-lane striping demux in the PCIe physical-layer transmit path.
- Sits between the byte/word source and the per-lane serialisers.
- Distributes valid input words round-robin across a runtime-selectable number of active lanes (x1/x2/x4/x8, capped at LANES), with registered outputs and per-lane valids.
- Marks stripe completion; link width changes take effect only at stripe boundaries.

Parameters:
WIDTH, 32, width of one data word / lane word in bits
LANES, 4, number of physical lanes instantiated; legal values 1, 2, 4, 8

Ports:
clk_2f  input  1  single clock; all state on rising edge
reset_L  input  1  asynchronous, active-low reset
data_input  input  WIDTH  word to stripe
valid_in  input  1  data_input valid this cycle
width_sel  input  2  requested link width: 0=x1, 1=x2, 2=x4, 3=x8
lane_data  output  LANES*WIDTH  flattened lane words; lane k occupies bits [k*WIDTH +: WIDTH]
valid_out  output  LANES  bit k high = lane k word valid this cycle
stripe_end  output  1  one-cycle pulse with the word that completes a stripe
active_lanes  output  4  currently effective lane count (1, 2, 4 or 8)

Behaviour:
- Reset (reset_L=0, asynchronous, any time including mid-stripe):
  - lane_data=0, valid_out=0, stripe_end=0.
  - Pointer ptr=0, active_lanes=1.
  - Release takes effect at the next clk_2f edge.
- Width decode: req = 1<<width_sel, clamped to LANES if req>LANES.
- Width latching: active_lanes <= decoded req on every edge where ptr==0 at the start of the cycle, regardless of valid_in.
  - A width_sel change while ptr!=0 is ignored until the stripe completes.
  - The word accepted in a ptr==0 cycle uses the new width for its own ptr wrap decision: eff = decoded req that cycle; otherwise eff = active_lanes.
- Accept (valid_in=1), every cycle, no backpressure:
  - lane_data[ptr] <= data_input; valid_out[ptr] <= 1.
  - All other valid_out bits <= 0; their lane_data words hold their previous values.
  - stripe_end <= (ptr==eff-1).
  - ptr <= (ptr==eff-1) ? 0 : ptr+1.
- Idle (valid_in=0):
  - valid_out <= 0, stripe_end <= 0, ptr holds, lane_data holds.
  - Gaps do not break a stripe; the next valid word continues at ptr.
- Latency: exactly 1 clk_2f cycle from data_input/valid_in to lane_data/valid_out.
- At most one valid_out bit is high in any cycle. Lanes >= active_lanes never assert valid.
- x1: every valid word goes to lane 0, and stripe_end pulses with every valid word.
- ptr width is clog2(LANES) bits (1 bit minimum). ptr never exceeds active_lanes-1.

Test Plan:
- Reset values: hold reset_L=0 for 3 cycles with random inputs -> all outputs 0, active_lanes=1. Assert reset_L=0 mid-stripe (ptr=2) -> outputs clear immediately without waiting for a clock edge. After release, first valid word lands on lane 0.
- x4 streaming: LANES=4, width_sel=2, valid_in=1 for words 0xA0..0xA7 -> lanes 0,1,2,3,0,1,2,3 receive the words in order, one cycle later. stripe_end is high with 0xA3 and 0xA7 only.
- Mid-stripe width change: x4; send 0xB0, 0xB1; set width_sel=1; send 0xB2..0xB5 -> 0xB2→lane2, 0xB3→lane3 (stripe_end), 0xB4→lane0, 0xB5→lane1 (stripe_end). active_lanes becomes 2 after the boundary.
- Gaps: x2; sequence 0xC0, idle, idle, 0xC1, idle, 0xC2 -> lane0=0xC0, lane1=0xC1 (stripe_end), lane0=0xC2. valid_out=0 during idles and lane_data holds.
- Clamp and x1: LANES=4, width_sel=3 -> active_lanes=4 and lanes 0..3 used. Then width_sel=0 at a boundary, send 0xD0, 0xD1 -> both on lane 0, stripe_end each cycle.
- Golden compare: random valid/width_sel for 2000 cycles, run against the synthesised netlist -> bit-exact match on all outputs every cycle.
